muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Decode issues MDU_en/MDU_op with the operand values. This unit computes the result and drives the busywait that freezes the front of the pipeline until the result is ready.
- Handles all 8 M-extension ops, including the RISC-V divide-by-zero and signed-overflow results.

Parameters:
- DATA_WIDTH, 32, operand/result width; also the iteration count.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- en_i  input  1  MDU instruction present in EX (registered MDU_en from ID/EX)
- op_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  input  DATA_WIDTH  forwarded rs1 value
- rs2_i  input  DATA_WIDTH  forwarded rs2 value
- flush_i  input  1  branch/exception flush of EX
- stall_i  input  1  downstream stall (memory busywait); holds a completed result
- busy_o  output  1  busywait request to the pipeline
- valid_o  output  1  result_o valid this cycle
- result_o  output  DATA_WIDTH  result for the writeback mux

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset: state=IDLE, result_o=0, valid_o=0, all internal registers 0. Reset also aborts any operation in flight.
- busy_o is combinational: (state==IDLE && en_i && !flush_i) || state==MUL || state==DIV. It is 0 in DONE.

IDLE:
- With en_i=1 and flush_i=0, latch op, rs1 and rs2.
- Special case, op DIV/DIVU/REM/REMU with rs2==0: go to DONE with quotient 0xFFFFFFFF, remainder = rs1.
- Special case, DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: go to DONE with quotient 0x80000000, remainder 0.
- Otherwise go to MUL (op[2]=0) or DIV (op[2]=1), and load the counter with DATA_WIDTH.

Operand preparation:
- Signed operands are converted to magnitudes, with the result sign recorded.
- rs1 is signed for MULH, MULHSU, DIV and REM.
- rs2 is signed for MULH, DIV and REM.
- The MUL low word is sign-independent.

MUL state:
- Shift-add, one multiplier bit per cycle.
- 2*DATA_WIDTH accumulator; 32 iterations.

DIV state:
- Restoring division, one quotient bit per cycle; 32 iterations.

End of iteration:
- When the counter reaches 0, apply the sign fix:
  - negate the 64-bit product if the signs differ;
  - negate the quotient if the dividend and divisor signs differ;
  - the remainder takes the dividend's sign.
- Then go to DONE.

Result selection:
- MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32].
- DIV/DIVU = quotient; REM/REMU = remainder.

DONE:
- valid_o=1 and result_o holds the result.
- Stay in DONE while stall_i=1 (no recompute).
- Else go to IDLE next cycle; valid_o drops.
- A back-to-back MDU instruction then presents en_i in IDLE and starts normally.

Latency (en_i seen in IDLE = cycle 0):
- Normal op: busy_o high cycles 0..32 (33 cycles); DONE at cycle 33.
- Special case: busy_o high cycle 0 only; DONE at cycle 1.

flush_i (any state):
- Next state IDLE, valid_o=0; result discarded.
- busy_o is 0 in the flush cycle when in IDLE; in MUL/DIV it drops the following cycle.
- flush_i outranks stall_i.

en_i deasserted while in MUL/DIV is ignored; only flush_i or rst_i abort.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> busy_o high exactly 33 cycles, then valid_o=1 with result_o=0xFFFFFFEB.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; each with busy_o high exactly 1 cycle.
- DIVU 1000/3 with flush_i pulsed at cycle 10 -> busy_o low from cycle 11, valid_o never set; next MUL 6*7 -> 42 after 33 busy cycles. Repeat with rst_i instead of flush_i -> same abort, outputs 0.
- MUL 3*4 completes with stall_i high 5 cycles -> valid_o high and result_o=12 held all 5 cycles, busy_o=0, no restart. Back-to-back MUL then DIVU, en_i held -> both results correct, DIVU starts the cycle after DONE.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with RISC-V divide-by-zero and signed-overflow results.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0]      OP_MULH   = 3'b001;
  localparam logic [2:0]      OP_MULHSU = 3'b010;
  localparam logic [2:0]      OP_DIV    = 3'b100;
  localparam logic [2:0]      OP_REM    = 3'b110;
  localparam logic [W-1:0]    ONE_W     = 1;
  localparam logic [2*W-1:0]  ONE_P     = 1;
  localparam logic [CW-1:0]   ONE_C     = 1;
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(W);
  localparam logic [W-1:0]    MIN_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [1:0]      op_lo;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    mcand;
  logic [W-1:0]    quo;
  logic [W-1:0]    rem;
  logic            neg_q;
  logic            neg_r;
  logic [CW-1:0]   count;

  logic            sgn1, sgn2, neg1, neg2;
  logic [W-1:0]    mag1, mag2;
  logic            div_zero, div_ovf;

  logic [W:0]      add_sum;
  logic [2*W-1:0]  prod_step;
  logic [2*W-1:0]  prod_fix;
  logic [W:0]      trial;
  logic [W:0]      diff;
  logic            ge;
  logic [W-1:0]    quo_step, rem_step;
  logic [W-1:0]    quo_fix, rem_fix;
  logic [W-1:0]    mul_res, div_res;

  assign busy_o = (state == IDLE && en_i && !flush_i) || state == MUL || state == DIV;

  always_comb begin
    sgn1     = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    sgn2     = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    neg1     = sgn1 && rs1_i[W-1];
    neg2     = sgn2 && rs2_i[W-1];
    mag1     = neg1 ? (~rs1_i + ONE_W) : rs1_i;
    mag2     = neg2 ? (~rs2_i + ONE_W) : rs2_i;
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == MIN_NEG) && (rs2_i == '1);
  end

  // prod holds {partial product, remaining multiplier bits}; the low half shifts out as it is consumed
  always_comb begin
    add_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mcand : '0)};
    prod_step = {add_sum, prod[W-1:1]};
    prod_fix  = neg_q ? (~prod_step + ONE_P) : prod_step;
    mul_res   = (op_lo == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
  end

  // quo starts as the dividend and fills with quotient bits from the right
  always_comb begin
    trial    = {rem, quo[W-1]};
    diff     = trial - {1'b0, mcand};
    ge       = !diff[W];
    rem_step = ge ? diff[W-1:0] : trial[W-1:0];
    quo_step = {quo[W-2:0], ge};
    quo_fix  = neg_q ? (~quo_step + ONE_W) : quo_step;
    rem_fix  = neg_r ? (~rem_step + ONE_W) : rem_step;
    div_res  = op_lo[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_lo    <= '0;
      prod     <= '0;
      mcand    <= '0;
      quo      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i) begin
            op_lo <= op_i[1:0];
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            if (div_zero) begin
              result_o <= op_i[1] ? rs1_i : '1;
              valid_o  <= 1'b1;
              state    <= DONE;
            end else if (div_ovf) begin
              result_o <= op_i[1] ? '0 : MIN_NEG;
              valid_o  <= 1'b1;
              state    <= DONE;
            end else begin
              count <= CNT_LOAD;
              mcand <= op_i[2] ? mag2 : mag1;
              prod  <= {{W{1'b0}}, mag2};
              quo   <= mag1;
              rem   <= '0;
              state <= op_i[2] ? DIV : MUL;
            end
          end
        end
        MUL: begin
          prod  <= prod_step;
          count <= count - ONE_C;
          if (count == ONE_C) begin
            result_o <= mul_res;
            valid_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DIV: begin
          quo   <= quo_step;
          rem   <= rem_step;
          count <= count - ONE_C;
          if (count == ONE_C) begin
            result_o <= div_res;
            valid_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!stall_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus hand-written
// sequences for flush/reset abort, stall hold and back-to-back issue.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .stall_i(stall), .busy_o(busy), .valid_o(valid), .result_o(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          busy;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // issue one op at cycle 0, drop en, count busy cycles until valid
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int bcnt, output bit got);
    res = '0; bcnt = 0; got = 0;
    @(posedge clk); #1;
    en = 1'b1; op = o; rs1 = a; rs2 = b;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (valid) begin
        got = 1;
        res = result;
        break;
      end
      @(posedge clk); #1;
      en = 1'b0;
    end
    en = 1'b0;
  endtask

  logic [31:0] res;
  int          bcnt;
  bit          got;
  int          cyc;
  bit          bad;

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33};
    vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[14] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
    vecs[15] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[16] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[17] = '{3'd5, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 33};
    vecs[18] = '{3'd4, 32'h8000_0000, 32'h0000_0003, 32'hD555_5556, 33};
    vecs[19] = '{3'd6, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 33};
    vecs[20] = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};

    rst = 1'b1; en = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy",   {31'b0, busy},  32'd0);
    check("reset_valid",  {31'b0, valid}, 32'd0);
    check("reset_result", result,         32'd0);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, bcnt, got);
      check($sformatf("vec%0d_valid", i),  {31'b0, got}, 32'd1);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_busy", i),   bcnt, vecs[i].busy);
    end

    // flush abort at cycle 10
    @(posedge clk); #1;
    en = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      en = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    check("flush_busy_c10", {31'b0, busy}, 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || valid) bad = 1;
      @(posedge clk); #1;
    end
    check("flush_quiet", {31'b0, bad}, 32'd0);
    do_op(3'd0, 32'd6, 32'd7, res, bcnt, got);
    check("post_flush_valid",  {31'b0, got}, 32'd1);
    check("post_flush_result", res, 32'd42);
    check("post_flush_busy",   bcnt, 33);

    // reset abort at cycle 10
    @(posedge clk); #1;
    en = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      en = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_abort_busy",   {31'b0, busy},  32'd0);
    check("rst_abort_valid",  {31'b0, valid}, 32'd0);
    check("rst_abort_result", result,         32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || valid) bad = 1;
    end
    check("rst_quiet", {31'b0, bad}, 32'd0);
    do_op(3'd0, 32'd6, 32'd7, res, bcnt, got);
    check("post_rst_result", res, 32'd42);
    check("post_rst_busy",   bcnt, 33);

    // stall holds DONE for 5 cycles
    @(posedge clk); #1;
    en = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; stall = 1'b1;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid) begin got = 1; break; end
      @(posedge clk); #1 en = 1'b0;
    end
    en = 1'b0;
    check("stall_reached_done", {31'b0, got}, 32'd1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (!valid || busy || result !== 32'd12) bad = 1;
      if (k == 4) stall = 1'b0;
    end
    check("stall_hold", {31'b0, bad}, 32'd0);
    @(negedge clk);
    check("stall_release_valid", {31'b0, valid}, 32'd0);
    check("stall_release_busy",  {31'b0, busy},  32'd0);

    // back-to-back with en held: MUL then DIVU
    @(posedge clk); #1;
    en = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd9;
    @(posedge clk); #1;
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd10;
    got = 0; cyc = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid) begin got = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_mul_valid",  {31'b0, got}, 32'd1);
    check("b2b_mul_cycle",  cyc, 33);
    check("b2b_mul_result", result, 32'd45);
    check("b2b_done_busy",  {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_div_start_busy",  {31'b0, busy},  32'd1);
    check("b2b_div_start_valid", {31'b0, valid}, 32'd0);
    @(posedge clk); #1 en = 1'b0;
    got = 0; cyc = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid) begin got = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_div_valid",  {31'b0, got}, 32'd1);
    check("b2b_div_cycle",  cyc, 33);
    check("b2b_div_result", result, 32'd10);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
